// File: rtl/axis_mon_run_ctrl.sv
// Test-run sequencer for one AXI4-Stream generator/monitor pair.
// A run clears the monitor, lets the generator send a programmed number of
// beats, waits for RX to catch up with TX (bounded by a timeout), then freezes
// a snapshot of the monitor statistics together with a pass/fail verdict.
module axis_mon_run_ctrl #(
  parameter int CLR_CYCLES = 4,
  parameter int BEAT_WIDTH = 32,
  parameter int TO_WIDTH   = 24,
  parameter int LOOPBACK   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [BEAT_WIDTH-1:0] cfg_beats,
  input  logic [TO_WIDTH-1:0]   cfg_timeout,
  input  logic                  tx_fire,
  input  logic [63:0]           mismatch_cnt,
  input  logic [63:0]           tx_pkt_cnt,
  input  logic [63:0]           rx_pkt_cnt,
  input  logic [63:0]           time_cnt,
  output logic                  mon_rst,
  output logic                  gen_en,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic                  aborted,
  output logic [63:0]           snap_mismatch,
  output logic [63:0]           snap_tx_pkt,
  output logic [63:0]           snap_rx_pkt,
  output logic [63:0]           snap_time
);

  localparam int              CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic [BEAT_WIDTH-1:0] cfg_beats_q;
  logic [TO_WIDTH-1:0]   cfg_timeout_q;

  logic [BEAT_WIDTH-1:0] beat_cnt;
  logic [BEAT_WIDTH-1:0] beat_nxt;
  logic [BEAT_WIDTH-1:0] beat_inc;
  logic [TO_WIDTH-1:0]   to_cnt;
  logic [TO_WIDTH-1:0]   to_nxt;
  logic [CLR_W-1:0]      clr_cnt;
  logic [CLR_W-1:0]      clr_nxt;

  logic                  timeout_nxt;
  logic                  aborted_nxt;
  logic                  accept;
  logic                  drain_match;
  logic                  done_entry;
  logic                  pass_nxt;

  // Saturating increments: counters stick at all-ones instead of wrapping.
  function automatic logic [BEAT_WIDTH-1:0] sat_inc_beat(input logic [BEAT_WIDTH-1:0] v);
    return (&v) ? v : v + BEAT_WIDTH'(1);
  endfunction

  function automatic logic [TO_WIDTH-1:0] sat_inc_to(input logic [TO_WIDTH-1:0] v);
    return (&v) ? v : v + TO_WIDTH'(1);
  endfunction

  function automatic logic [CLR_W-1:0] sat_inc_clr(input logic [CLR_W-1:0] v);
    return (&v) ? v : v + CLR_W'(1);
  endfunction

  assign beat_inc    = sat_inc_beat(beat_cnt);
  // Without a loopback path there is nothing to wait for: drain is one cycle.
  assign drain_match = (LOOPBACK == 0) || (rx_pkt_cnt == tx_pkt_cnt);
  assign done_entry  = (state_nxt == S_DONE) && (state != S_DONE);
  assign pass_nxt    = ~timeout_nxt & ~aborted_nxt & (mismatch_cnt == 64'd0) &
                       (tx_pkt_cnt == rx_pkt_cnt);

  // Next-state, counter and result-flag decisions for the run sequencer.
  always_comb begin
    state_nxt   = state;
    beat_nxt    = beat_cnt;
    to_nxt      = to_cnt;
    clr_nxt     = clr_cnt;
    timeout_nxt = timeout;
    aborted_nxt = aborted;
    accept      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        // start outranks a simultaneous abort; a lone abort is ignored here
        if (start) begin
          state_nxt   = S_CLEAR;
          accept      = 1'b1;
          beat_nxt    = '0;
          to_nxt      = '0;
          clr_nxt     = '0;
          timeout_nxt = 1'b0;
          aborted_nxt = 1'b0;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          aborted_nxt = 1'b1;
          state_nxt   = S_DRAIN;
        end else if (clr_cnt == CLR_LAST) begin
          state_nxt = (cfg_beats_q == '0) ? S_DRAIN : S_RUN;
        end else begin
          clr_nxt = sat_inc_clr(clr_cnt);
        end
      end
      S_RUN: begin
        if (abort) begin
          aborted_nxt = 1'b1;
          state_nxt   = S_DRAIN;
        end else if (tx_fire && gen_en) begin
          beat_nxt = beat_inc;
          // leave on the final beat's edge so gen_en drops before another beat
          if (beat_inc == cfg_beats_q) begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          aborted_nxt = 1'b1;
          state_nxt   = S_DONE;
        end else if (drain_match) begin
          state_nxt = S_DONE;
        end else if (to_cnt == cfg_timeout_q) begin
          timeout_nxt = 1'b1;
          state_nxt   = S_DONE;
        end else begin
          to_nxt = sat_inc_to(to_cnt);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counters, result flags and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      to_cnt   <= '0;
      clr_cnt  <= '0;
      timeout  <= 1'b0;
      aborted  <= 1'b0;
      pass     <= 1'b0;
      mon_rst  <= 1'b1;
      gen_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      beat_cnt <= beat_nxt;
      to_cnt   <= to_nxt;
      clr_cnt  <= clr_nxt;
      timeout  <= timeout_nxt;
      aborted  <= aborted_nxt;
      mon_rst  <= (state_nxt == S_CLEAR);
      gen_en   <= (state_nxt == S_RUN);
      busy     <= (state_nxt == S_CLEAR) || (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done     <= (state_nxt == S_DONE);
      if (accept) begin
        pass <= 1'b0;
      end else if (done_entry) begin
        pass <= pass_nxt;
      end
    end
  end

  // Statistics snapshot, frozen on the edge into DONE and held until the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_mismatch <= '0;
      snap_tx_pkt   <= '0;
      snap_rx_pkt   <= '0;
      snap_time     <= '0;
    end else if (done_entry) begin
      snap_mismatch <= mismatch_cnt;
      snap_tx_pkt   <= tx_pkt_cnt;
      snap_rx_pkt   <= rx_pkt_cnt;
      snap_time     <= time_cnt;
    end
  end

  // Run configuration, captured when a start is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      cfg_beats_q   <= cfg_beats;
      cfg_timeout_q <= cfg_timeout;
    end
  end

endmodule

// File: tb/tb_axis_mon_run_ctrl.sv
// Bench for axis_mon_run_ctrl: a small generator/monitor model with a
// three-cycle loopback, optional RX drop and mismatch injection.
module tb_axis_mon_run_ctrl;

  localparam int BW = 32;
  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          tready;
  logic          stray;
  logic [BW-1:0] cfg_beats;
  logic [TW-1:0] cfg_timeout;
  logic          tx_fire;
  logic          gen_fire;
  logic [63:0]   mismatch_cnt;
  logic [63:0]   tx_pkt_cnt;
  logic [63:0]   rx_pkt_cnt;
  logic [63:0]   time_cnt;
  logic          mon_rst;
  logic          gen_en;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic          aborted;
  logic [63:0]   snap_mismatch;
  logic [63:0]   snap_tx_pkt;
  logic [63:0]   snap_rx_pkt;
  logic [63:0]   snap_time;

  logic [2:0]    pipe;
  int            seen;
  int            drop_idx;
  int            bad_idx;

  int            checks   = 0;
  int            failures = 0;

  typedef struct {
    bit     pass;
    bit     timeout;
    bit     aborted;
    int     fires;
    int     mon_cyc;
    int     drain_cyc;
    longint snap_tx;
    longint snap_rx;
    longint snap_mis;
  } exp_t;

  exp_t          exp_q[$];

  int            obs_mon;
  int            obs_gen;
  int            obs_fires;
  int            obs_drain;
  bit            obs_done;
  bit            obs_last_fire;
  logic [63:0]   time_at_done;

  always #5 clk = ~clk;

  assign gen_fire = gen_en & tready;
  assign tx_fire  = gen_fire | stray;

  axis_mon_run_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_beats     (cfg_beats),
    .cfg_timeout   (cfg_timeout),
    .tx_fire       (tx_fire),
    .mismatch_cnt  (mismatch_cnt),
    .tx_pkt_cnt    (tx_pkt_cnt),
    .rx_pkt_cnt    (rx_pkt_cnt),
    .time_cnt      (time_cnt),
    .mon_rst       (mon_rst),
    .gen_en        (gen_en),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .aborted       (aborted),
    .snap_mismatch (snap_mismatch),
    .snap_tx_pkt   (snap_tx_pkt),
    .snap_rx_pkt   (snap_rx_pkt),
    .snap_time     (snap_time)
  );

  // Monitor model: counts real generator beats, delivers them to RX three
  // cycles later, optionally drops or corrupts one packet; cleared by mon_rst.
  always @(posedge clk) begin
    if (mon_rst) begin
      tx_pkt_cnt   <= 64'd0;
      rx_pkt_cnt   <= 64'd0;
      time_cnt     <= 64'd0;
      mismatch_cnt <= 64'd0;
      pipe         <= 3'b000;
      seen         <= 0;
    end else begin
      time_cnt <= time_cnt + 64'd1;
      pipe     <= {pipe[1:0], gen_fire};
      if (gen_fire) tx_pkt_cnt <= tx_pkt_cnt + 64'd1;
      if (pipe[2]) begin
        seen <= seen + 1;
        if (seen != drop_idx) rx_pkt_cnt <= rx_pkt_cnt + 64'd1;
        if (seen == bad_idx) mismatch_cnt <= mismatch_cnt + 64'd1;
      end
    end
  end

  // Drives one run from start to done and records what was observed.
  task automatic run_once(input int beats, input int to, input bit toggle,
                          input int abort_c, input bit start_mid, input bit abort_on_start);
    @(negedge clk);
    cfg_beats   = BW'(beats);
    cfg_timeout = TW'(to);
    start       = 1'b1;
    abort       = abort_on_start;
    @(negedge clk);
    start         = 1'b0;
    abort         = 1'b0;
    obs_mon       = 0;
    obs_gen       = 0;
    obs_fires     = 0;
    obs_drain     = 0;
    obs_done      = 1'b0;
    obs_last_fire = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        obs_done = 1'b1;
        break;
      end
      if (mon_rst) obs_mon++;
      if (busy && !mon_rst && !gen_en) obs_drain++;
      tready = toggle ? c[0] : 1'b1;
      stray  = (c == 1);
      if (gen_en) begin
        obs_gen++;
        obs_last_fire = tready;
        if (tready) obs_fires++;
      end
      abort        = (c == abort_c);
      start        = start_mid && (c == 5);
      time_at_done = time_cnt;
      @(negedge clk);
    end
    start  = 1'b0;
    abort  = 1'b0;
    stray  = 1'b0;
    tready = 1'b1;
  endtask

  task automatic test_reset;
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    tready      = 1'b1;
    stray       = 1'b0;
    cfg_beats   = '0;
    cfg_timeout = '0;
    drop_idx    = -1;
    bad_idx     = -1;
    repeat (3) @(negedge clk);
    checks++; if (mon_rst !== 1'b1) begin failures++; $display("FAIL reset_mon_rst got=%b exp=1", mon_rst); end
    checks++; if ({gen_en, busy, done, pass, timeout, aborted} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {gen_en, busy, done, pass, timeout, aborted}); end
    checks++; if ((snap_mismatch | snap_tx_pkt | snap_rx_pkt | snap_time) !== 64'd0) begin failures++; $display("FAIL reset_snap got=%0h exp=0", snap_mismatch | snap_tx_pkt | snap_rx_pkt | snap_time); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mon_rst !== 1'b0) begin failures++; $display("FAIL reset_release_mon_rst got=%b exp=0", mon_rst); end
  endtask

  task automatic test_basic;
    exp_t e;
    exp_q.push_back('{pass: 1, timeout: 0, aborted: 0, fires: 8, mon_cyc: 4, drain_cyc: 4, snap_tx: 8, snap_rx: 8, snap_mis: 0});
    run_once(8, 100, 1'b0, -1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs_done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", obs_done); end
    checks++; if (obs_mon !== e.mon_cyc) begin failures++; $display("FAIL basic_mon_rst_cycles got=%0d exp=%0d", obs_mon, e.mon_cyc); end
    checks++; if (obs_fires !== e.fires || obs_gen !== e.fires) begin failures++; $display("FAIL basic_fires got=%0d/%0d exp=%0d", obs_fires, obs_gen, e.fires); end
    checks++; if (obs_drain !== e.drain_cyc) begin failures++; $display("FAIL basic_drain got=%0d exp=%0d", obs_drain, e.drain_cyc); end
    checks++; if ({pass, timeout, aborted} !== {e.pass, e.timeout, e.aborted}) begin failures++; $display("FAIL basic_flags got=%b exp=%b", {pass, timeout, aborted}, {e.pass, e.timeout, e.aborted}); end
    checks++; if (snap_tx_pkt !== 64'(e.snap_tx) || snap_rx_pkt !== 64'(e.snap_rx)) begin failures++; $display("FAIL basic_snap_pkt got=%0d/%0d exp=%0d/%0d", snap_tx_pkt, snap_rx_pkt, e.snap_tx, e.snap_rx); end
    checks++; if (snap_time !== time_at_done) begin failures++; $display("FAIL basic_snap_time got=%0d exp=%0d", snap_time, time_at_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_in_done got=%b exp=0", busy); end
  endtask

  task automatic test_tready_toggle;
    exp_t e;
    exp_q.push_back('{pass: 1, timeout: 0, aborted: 0, fires: 8, mon_cyc: 4, drain_cyc: -1, snap_tx: 8, snap_rx: 8, snap_mis: 0});
    run_once(8, 100, 1'b1, -1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs_fires !== e.fires) begin failures++; $display("FAIL toggle_fires got=%0d exp=%0d", obs_fires, e.fires); end
    checks++; if (obs_last_fire !== 1'b1 || obs_gen !== 16) begin failures++; $display("FAIL toggle_gen_en_drop got=%0d/%b exp=16/1", obs_gen, obs_last_fire); end
    checks++; if (pass !== e.pass || snap_tx_pkt !== 64'(e.snap_tx)) begin failures++; $display("FAIL toggle_result got=%b/%0d exp=%b/%0d", pass, snap_tx_pkt, e.pass, e.snap_tx); end
  endtask

  task automatic test_timeout;
    exp_t e;
    drop_idx = 3;
    exp_q.push_back('{pass: 0, timeout: 1, aborted: 0, fires: 8, mon_cyc: 4, drain_cyc: 21, snap_tx: 8, snap_rx: 7, snap_mis: 0});
    run_once(8, 20, 1'b0, -1, 1'b0, 1'b0);
    drop_idx = -1;
    e = exp_q.pop_front();
    checks++; if (obs_done !== 1'b1) begin failures++; $display("FAIL timeout_done got=%b exp=1", obs_done); end
    checks++; if (obs_drain !== e.drain_cyc) begin failures++; $display("FAIL timeout_drain got=%0d exp=%0d", obs_drain, e.drain_cyc); end
    checks++; if ({pass, timeout, aborted} !== {e.pass, e.timeout, e.aborted}) begin failures++; $display("FAIL timeout_flags got=%b exp=%b", {pass, timeout, aborted}, {e.pass, e.timeout, e.aborted}); end
    checks++; if (snap_rx_pkt !== 64'(e.snap_rx)) begin failures++; $display("FAIL timeout_snap_rx got=%0d exp=%0d", snap_rx_pkt, e.snap_rx); end
    // cfg_timeout of zero: one drain cycle while RX still lags
    exp_q.push_back('{pass: 0, timeout: 1, aborted: 0, fires: 2, mon_cyc: 4, drain_cyc: 1, snap_tx: 2, snap_rx: 0, snap_mis: 0});
    run_once(2, 0, 1'b0, -1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs_drain !== e.drain_cyc || timeout !== e.timeout) begin failures++; $display("FAIL timeout_zero got=%0d/%b exp=%0d/%b", obs_drain, timeout, e.drain_cyc, e.timeout); end
    checks++; if (snap_tx_pkt !== 64'(e.snap_tx) || snap_rx_pkt !== 64'(e.snap_rx)) begin failures++; $display("FAIL timeout_zero_snap got=%0d/%0d exp=%0d/%0d", snap_tx_pkt, snap_rx_pkt, e.snap_tx, e.snap_rx); end
  endtask

  task automatic test_abort;
    exp_t e;
    exp_q.push_back('{pass: 0, timeout: 0, aborted: 1, fires: 3, mon_cyc: 4, drain_cyc: -1, snap_tx: 3, snap_rx: 3, snap_mis: 0});
    run_once(8, 100, 1'b0, 6, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs_gen !== e.fires || obs_fires !== e.fires) begin failures++; $display("FAIL abort_run_gen_en got=%0d/%0d exp=%0d", obs_gen, obs_fires, e.fires); end
    checks++; if ({pass, timeout, aborted} !== {e.pass, e.timeout, e.aborted}) begin failures++; $display("FAIL abort_run_flags got=%b exp=%b", {pass, timeout, aborted}, {e.pass, e.timeout, e.aborted}); end
    checks++; if (snap_tx_pkt !== 64'(e.snap_tx) || snap_rx_pkt !== 64'(e.snap_rx)) begin failures++; $display("FAIL abort_run_snap got=%0d/%0d exp=%0d/%0d", snap_tx_pkt, snap_rx_pkt, e.snap_tx, e.snap_rx); end
    // abort during CLEAR cuts the monitor reset short
    exp_q.push_back('{pass: 0, timeout: 0, aborted: 1, fires: 0, mon_cyc: 2, drain_cyc: 1, snap_tx: 0, snap_rx: 0, snap_mis: 0});
    run_once(8, 100, 1'b0, 1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs_mon !== e.mon_cyc || obs_gen !== 0) begin failures++; $display("FAIL abort_clear_mon_rst got=%0d/%0d exp=%0d/0", obs_mon, obs_gen, e.mon_cyc); end
    checks++; if (obs_drain !== e.drain_cyc || aborted !== e.aborted || pass !== e.pass) begin failures++; $display("FAIL abort_clear_result got=%0d/%b/%b exp=%0d/%b/%b", obs_drain, aborted, pass, e.drain_cyc, e.aborted, e.pass); end
  endtask

  task automatic test_zero_beats;
    exp_t e;
    exp_q.push_back('{pass: 1, timeout: 0, aborted: 0, fires: 0, mon_cyc: 4, drain_cyc: 1, snap_tx: 0, snap_rx: 0, snap_mis: 0});
    run_once(0, 100, 1'b0, -1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs_gen !== 0) begin failures++; $display("FAIL zero_gen_en got=%0d exp=0", obs_gen); end
    checks++; if (obs_mon !== e.mon_cyc || obs_drain !== e.drain_cyc) begin failures++; $display("FAIL zero_phases got=%0d/%0d exp=%0d/%0d", obs_mon, obs_drain, e.mon_cyc, e.drain_cyc); end
    checks++; if (obs_done !== 1'b1 || pass !== e.pass) begin failures++; $display("FAIL zero_pass got=%b/%b exp=1/%b", obs_done, pass, e.pass); end
    checks++; if (snap_tx_pkt !== 64'(e.snap_tx) || snap_rx_pkt !== 64'(e.snap_rx)) begin failures++; $display("FAIL zero_snap got=%0d/%0d exp=0/0", snap_tx_pkt, snap_rx_pkt); end
  endtask

  task automatic test_mismatch;
    exp_t e;
    bad_idx = 1;
    exp_q.push_back('{pass: 0, timeout: 0, aborted: 0, fires: 4, mon_cyc: 4, drain_cyc: -1, snap_tx: 4, snap_rx: 4, snap_mis: 1});
    run_once(4, 100, 1'b0, -1, 1'b0, 1'b0);
    bad_idx = -1;
    e = exp_q.pop_front();
    checks++; if ({pass, timeout, aborted} !== {e.pass, e.timeout, e.aborted}) begin failures++; $display("FAIL mismatch_flags got=%b exp=%b", {pass, timeout, aborted}, {e.pass, e.timeout, e.aborted}); end
    checks++; if (snap_mismatch !== 64'(e.snap_mis)) begin failures++; $display("FAIL mismatch_snap got=%0d exp=%0d", snap_mismatch, e.snap_mis); end
  endtask

  task automatic test_rst_mid_run;
    exp_t e;
    @(negedge clk);
    cfg_beats   = BW'(8);
    cfg_timeout = TW'(100);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (gen_en !== 1'b1) begin failures++; $display("FAIL rstmid_running got=%b exp=1", gen_en); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mon_rst !== 1'b1) begin failures++; $display("FAIL rstmid_mon_rst got=%b exp=1", mon_rst); end
    checks++; if ({gen_en, busy, done, pass, timeout, aborted} !== 6'b0) begin failures++; $display("FAIL rstmid_flags got=%b exp=000000", {gen_en, busy, done, pass, timeout, aborted}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mon_rst !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_release got=%b/%b exp=0/0", mon_rst, busy); end
    exp_q.push_back('{pass: 1, timeout: 0, aborted: 0, fires: 8, mon_cyc: 4, drain_cyc: 4, snap_tx: 8, snap_rx: 8, snap_mis: 0});
    run_once(8, 100, 1'b0, -1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (pass !== e.pass || obs_fires !== e.fires) begin failures++; $display("FAIL rstmid_second_run got=%b/%0d exp=%b/%0d", pass, obs_fires, e.pass, e.fires); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    // lone abort while DONE is ignored
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (done !== 1'b1 || aborted !== 1'b0) begin failures++; $display("FAIL b2b_abort_in_done got=%b/%b exp=1/0", done, aborted); end
    // start together with abort: start wins
    exp_q.push_back('{pass: 1, timeout: 0, aborted: 0, fires: 3, mon_cyc: 4, drain_cyc: -1, snap_tx: 3, snap_rx: 3, snap_mis: 0});
    run_once(3, 100, 1'b0, -1, 1'b0, 1'b1);
    e = exp_q.pop_front();
    checks++; if (obs_mon !== e.mon_cyc || obs_fires !== e.fires) begin failures++; $display("FAIL b2b_start_wins got=%0d/%0d exp=%0d/%0d", obs_mon, obs_fires, e.mon_cyc, e.fires); end
    checks++; if ({pass, aborted} !== {e.pass, e.aborted} || snap_tx_pkt !== 64'(e.snap_tx)) begin failures++; $display("FAIL b2b_start_wins_result got=%b%b/%0d exp=%b%b/%0d", pass, aborted, snap_tx_pkt, e.pass, e.aborted, e.snap_tx); end
    // start while running is ignored
    exp_q.push_back('{pass: 1, timeout: 0, aborted: 0, fires: 8, mon_cyc: 4, drain_cyc: 4, snap_tx: 8, snap_rx: 8, snap_mis: 0});
    run_once(8, 100, 1'b0, -1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs_mon !== e.mon_cyc || obs_fires !== e.fires || obs_drain !== e.drain_cyc) begin failures++; $display("FAIL b2b_start_mid got=%0d/%0d/%0d exp=%0d/%0d/%0d", obs_mon, obs_fires, obs_drain, e.mon_cyc, e.fires, e.drain_cyc); end
    checks++; if (pass !== e.pass || snap_rx_pkt !== 64'(e.snap_rx)) begin failures++; $display("FAIL b2b_start_mid_result got=%b/%0d exp=%b/%0d", pass, snap_rx_pkt, e.pass, e.snap_rx); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tready_toggle();
    test_timeout();
    test_abort();
    test_zero_beats();
    test_mismatch();
    test_rst_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
